// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port IDs and
// the width of the per-port wait counters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        HELD_A = 2'd1,
        HELD_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Wide enough for any MAX_WAIT in 1..255.
    localparam int unsigned WAIT_CNT_W = 8;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// Saturating count of consecutive refused cycles for one requester;
// flags starvation once the count reaches MAX_WAIT.
module arb_wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic valid,
    input  logic ready,
    output logic starved
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (!valid || ready) begin
            count <= '0;
        end else if (count != WAIT_CNT_W'(MAX_WAIT)) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (count == WAIT_CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: round-robin
// with bus lock and a starvation bound, plus read-response routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_valid,
    input  logic              a_write,
    input  logic [3:0]        a_wmask,
    input  logic [31:0]       a_wdata,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_lock,
    output logic              a_ready,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,
    input  logic              b_valid,
    input  logic              b_write,
    input  logic [3:0]        b_wmask,
    input  logic [31:0]       b_wdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_lock,
    output logic              b_ready,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,
    output logic              m_valid,
    output logic              m_write,
    output logic [3:0]        m_wmask,
    output logic [31:0]       m_wdata,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_rdata
);

    arb_state_e state;
    port_e      last_grant;
    logic       a_starved;
    logic       b_starved;
    logic       grant_a;
    logic       grant_b;

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_a (
        .clk     (clk),
        .rstn    (rstn),
        .valid   (a_valid),
        .ready   (a_ready),
        .starved (a_starved)
    );

    arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait_b (
        .clk     (clk),
        .rstn    (rstn),
        .valid   (b_valid),
        .ready   (b_ready),
        .starved (b_starved)
    );

    // Starvation only matters in a tie; while locked it is ignored entirely.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            HELD_A: grant_a = a_valid;
            HELD_B: grant_b = b_valid;
            default: begin
                if (a_valid && !b_valid) begin
                    grant_a = 1'b1;
                end else if (b_valid && !a_valid) begin
                    grant_b = 1'b1;
                end else if (a_valid && b_valid) begin
                    if (a_starved)                 grant_a = 1'b1;
                    else if (b_starved)            grant_b = 1'b1;
                    else if (last_grant == PORT_B) grant_a = 1'b1;
                    else                           grant_b = 1'b1;
                end
            end
        endcase
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign m_valid = grant_a | grant_b;

    always_comb begin
        m_write = 1'b0;
        m_wmask = '0;
        m_wdata = '0;
        m_addr  = '0;
        if (grant_a) begin
            m_write = a_write;
            m_wmask = a_wmask;
            m_wdata = a_wdata;
            m_addr  = a_addr;
        end else if (grant_b) begin
            m_write = b_write;
            m_wmask = b_wmask;
            m_wdata = b_wdata;
            m_addr  = b_addr;
        end
    end

    assign a_rdata = m_rdata;
    assign b_rdata = m_rdata;

    // The two rvalid flags double as the registered read owner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= FREE;
            last_grant <= PORT_B;
            a_rvalid   <= 1'b0;
            b_rvalid   <= 1'b0;
        end else begin
            if (grant_a)      last_grant <= PORT_A;
            else if (grant_b) last_grant <= PORT_B;

            a_rvalid <= grant_a && !a_write;
            b_rvalid <= grant_b && !b_write;

            case (state)
                FREE: begin
                    if (grant_a && a_lock)      state <= HELD_A;
                    else if (grant_b && b_lock) state <= HELD_B;
                end
                HELD_A: begin
                    if ((grant_a && !a_lock) || (!a_valid && !a_lock)) state <= FREE;
                end
                HELD_B: begin
                    if ((grant_b && !b_lock) || (!b_valid && !b_lock)) state <= FREE;
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table with hand-computed grants
// and read responses against a 1-cycle-latency memory model, plus a reset case.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        a_valid, a_write, a_lock, a_ready, a_rvalid;
    logic [3:0]  a_wmask;
    logic [31:0] a_wdata, a_addr, a_rdata;
    logic        b_valid, b_write, b_lock, b_ready, b_rvalid;
    logic [3:0]  b_wmask;
    logic [31:0] b_wdata, b_addr, b_rdata;
    logic        m_valid, m_write;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata, m_addr, m_rdata;

    mem_arbiter #(.ADDR_W(32), .MAX_WAIT(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .a_valid  (a_valid),
        .a_write  (a_write),
        .a_wmask  (a_wmask),
        .a_wdata  (a_wdata),
        .a_addr   (a_addr),
        .a_lock   (a_lock),
        .a_ready  (a_ready),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_valid  (b_valid),
        .b_write  (b_write),
        .b_wmask  (b_wmask),
        .b_wdata  (b_wdata),
        .b_addr   (b_addr),
        .b_lock   (b_lock),
        .b_ready  (b_ready),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .m_valid  (m_valid),
        .m_write  (m_write),
        .m_wmask  (m_wmask),
        .m_wdata  (m_wdata),
        .m_addr   (m_addr),
        .m_rdata  (m_rdata)
    );

    // Memory model: word i holds A000_0000+i, except 0x100 holds DEADBEEF.
    logic [31:0] mem [256];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
            mem[64]    <= 32'hDEAD_BEEF;
            mem_loaded <= 1'b1;
        end else if (m_valid) begin
            if (m_write) begin
                for (int j = 0; j < 4; j++)
                    if (m_wmask[j]) mem[m_addr[9:2]][j*8 +: 8] <= m_wdata[j*8 +: 8];
            end else begin
                m_rdata <= mem[m_addr[9:2]];
            end
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ctl = {valid, write, lock}; exp = {a_ready, b_ready, a_rvalid, b_rvalid}
    typedef struct {
        logic [2:0]  a_ctl;
        logic [31:0] a_addr;
        logic [2:0]  b_ctl;
        logic [31:0] b_addr;
        logic [3:0]  exp;
        logic [31:0] erd;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    logic [31:0] exp_maddr;

    initial begin
        // Round-robin from reset, alternating reads
        tbl[0]  = '{3'b100, 32'h104, 3'b100, 32'h204, 4'b1000, 32'h0};
        tbl[1]  = '{3'b100, 32'h108, 3'b100, 32'h204, 4'b0110, 32'hA000_0041};
        tbl[2]  = '{3'b100, 32'h108, 3'b100, 32'h208, 4'b1001, 32'hA000_0081};
        tbl[3]  = '{3'b100, 32'h10C, 3'b100, 32'h208, 4'b0110, 32'hA000_0042};
        tbl[4]  = '{3'b000, 32'h0,   3'b000, 32'h0,   4'b0001, 32'hA000_0082};
        // Single A read of 0x100
        tbl[5]  = '{3'b100, 32'h100, 3'b000, 32'h0,   4'b1000, 32'h0};
        tbl[6]  = '{3'b000, 32'h0,   3'b000, 32'h0,   4'b0010, 32'hDEAD_BEEF};
        // Masked B write then A read-back
        tbl[7]  = '{3'b000, 32'h0,   3'b110, 32'h200, 4'b0100, 32'h0};
        tbl[8]  = '{3'b100, 32'h200, 3'b000, 32'h0,   4'b1000, 32'h0};
        tbl[9]  = '{3'b000, 32'h0,   3'b110, 32'h300, 4'b0110, 32'hA000_3344};
        // A locks for 4 accesses while B waits, then releases
        tbl[10] = '{3'b101, 32'h110, 3'b100, 32'h210, 4'b1000, 32'h0};
        tbl[11] = '{3'b101, 32'h114, 3'b100, 32'h210, 4'b1010, 32'hA000_0044};
        tbl[12] = '{3'b101, 32'h118, 3'b100, 32'h210, 4'b1010, 32'hA000_0045};
        tbl[13] = '{3'b101, 32'h11C, 3'b100, 32'h210, 4'b1010, 32'hA000_0046};
        tbl[14] = '{3'b100, 32'h120, 3'b100, 32'h210, 4'b1010, 32'hA000_0047};
        tbl[15] = '{3'b100, 32'h124, 3'b100, 32'h210, 4'b0110, 32'hA000_0048};
        tbl[16] = '{3'b100, 32'h124, 3'b000, 32'h0,   4'b1001, 32'hA000_0084};
        tbl[17] = '{3'b000, 32'h0,   3'b000, 32'h0,   4'b0010, 32'hA000_0049};
        // Lock held with no access; B saturates, release by idle cycle
        tbl[18] = '{3'b101, 32'h130, 3'b000, 32'h0,   4'b1000, 32'h0};
        tbl[19] = '{3'b001, 32'h0,   3'b100, 32'h230, 4'b0010, 32'hA000_004C};
        tbl[20] = '{3'b001, 32'h0,   3'b100, 32'h230, 4'b0000, 32'h0};
        tbl[21] = '{3'b000, 32'h0,   3'b100, 32'h230, 4'b0000, 32'h0};
        tbl[22] = '{3'b100, 32'h134, 3'b100, 32'h230, 4'b0100, 32'h0};
        tbl[23] = '{3'b100, 32'h134, 3'b000, 32'h0,   4'b1001, 32'hA000_008C};
        tbl[24] = '{3'b000, 32'h0,   3'b000, 32'h0,   4'b0010, 32'hA000_004D};

        rstn    = 1'b0;
        a_valid = 1'b0; a_write = 1'b0; a_lock = 1'b0; a_addr = '0;
        b_valid = 1'b0; b_write = 1'b0; b_lock = 1'b0; b_addr = '0;
        a_wdata = 32'h5566_7788; a_wmask = 4'hF;
        b_wdata = 32'h1122_3344; b_wmask = 4'b0011;

        repeat (3) @(posedge clk);
        #1;
        chk("rst a_ready",  32'(a_ready),  32'h0);
        chk("rst b_ready",  32'(b_ready),  32'h0);
        chk("rst m_valid",  32'(m_valid),  32'h0);
        chk("rst m_addr",   m_addr,        32'h0);
        chk("rst a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst b_rvalid", 32'(b_rvalid), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            {a_valid, a_write, a_lock} = tbl[i].a_ctl;
            a_addr                     = tbl[i].a_addr;
            {b_valid, b_write, b_lock} = tbl[i].b_ctl;
            b_addr                     = tbl[i].b_addr;
            #1;
            exp_maddr = tbl[i].exp[3] ? tbl[i].a_addr : (tbl[i].exp[2] ? tbl[i].b_addr : 32'h0);
            chk($sformatf("v%0d a_ready", i),  32'(a_ready),  32'(tbl[i].exp[3]));
            chk($sformatf("v%0d b_ready", i),  32'(b_ready),  32'(tbl[i].exp[2]));
            chk($sformatf("v%0d m_valid", i),  32'(m_valid),  32'(tbl[i].exp[3] | tbl[i].exp[2]));
            chk($sformatf("v%0d m_addr", i),   m_addr,        exp_maddr);
            chk($sformatf("v%0d a_rvalid", i), 32'(a_rvalid), 32'(tbl[i].exp[1]));
            chk($sformatf("v%0d b_rvalid", i), 32'(b_rvalid), 32'(tbl[i].exp[0]));
            if (tbl[i].exp[1] || tbl[i].exp[0]) begin
                chk($sformatf("v%0d a_rdata", i), a_rdata, tbl[i].erd);
                chk($sformatf("v%0d b_rdata", i), b_rdata, tbl[i].erd);
            end
            @(posedge clk);
            #1;
        end

        // Reset lands in the cycle an A read is accepted: response is dropped.
        a_valid = 1'b1; a_write = 1'b0; a_lock = 1'b0; a_addr = 32'h100;
        b_valid = 1'b0; b_write = 1'b0; b_lock = 1'b0; b_addr = '0;
        #1;
        chk("rsq a_ready", 32'(a_ready), 32'h1);
        @(negedge clk);
        rstn    = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("rsq m_valid in reset",  32'(m_valid),  32'h0);
        chk("rsq a_rvalid in reset", 32'(a_rvalid), 32'h0);
        @(posedge clk);
        #1;
        chk("rsq a_rvalid held", 32'(a_rvalid), 32'h0);
        chk("rsq b_rvalid held", 32'(b_rvalid), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rsq a_rvalid after", 32'(a_rvalid), 32'h0);
        a_valid = 1'b1; a_addr = 32'h104;
        b_valid = 1'b1; b_addr = 32'h204;
        #1;
        chk("rsq tie a_ready", 32'(a_ready), 32'h1);
        chk("rsq tie b_ready", 32'(b_ready), 32'h0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("rsq tie a_rvalid", 32'(a_rvalid), 32'h1);
        chk("rsq tie a_rdata",  a_rdata,       32'hA000_0041);
        chk("rsq tie b_ready",  32'(b_ready),  32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
